// File: rtl/reel_spin_ctrl.sv
// Reel spin controller: spins three reels to latched targets with staggered
// stops, and latches win/total credit values for the display.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start_spin, reelN_idx : spin request and target symbols
//   is_win/win_credits    : win strobe and amount
//   is_total/total_credits: balance strobe and amount
//   reelN_pos             : displayed symbol per reel
//   spinning, spin_done   : busy level and end-of-spin pulse
//   win_disp/win_show     : latched win amount and its display enable
//   total_disp            : latched credit balance
module reel_spin_ctrl #(
  parameter int NUM_SYMBOLS   = 10,
  parameter int STEP_DIV      = 250000,
  parameter int MIN_STEPS     = 30,
  parameter int STAGGER_STEPS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_spin,
  input  logic [3:0]  reel1_idx,
  input  logic [3:0]  reel2_idx,
  input  logic [3:0]  reel3_idx,
  input  logic        is_win,
  input  logic [11:0] win_credits,
  input  logic        is_total,
  input  logic [11:0] total_credits,
  output logic [3:0]  reel1_pos,
  output logic [3:0]  reel2_pos,
  output logic [3:0]  reel3_pos,
  output logic        spinning,
  output logic        spin_done,
  output logic [11:0] win_disp,
  output logic        win_show,
  output logic [11:0] total_disp
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(STEP_DIV - 1);
  localparam logic [3:0] SYM_MAX = 4'(NUM_SYMBOLS - 1);
  localparam logic [15:0] THR1 = 16'(MIN_STEPS);
  localparam logic [15:0] THR2 = 16'(MIN_STEPS + STAGGER_STEPS);
  localparam logic [15:0] THR3 = 16'(MIN_STEPS + 2 * STAGGER_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2:0][3:0]  pos;
  logic [2:0][3:0]  tgt;
  logic [2:0][15:0] thr;
  logic [2:0]       stopped;
  logic [2:0]       stop_now;
  logic [TW-1:0]    tick;
  logic [15:0]      steps;
  logic [15:0]      steps_n;
  logic             step;
  logic             all_stop;
  logic             win_pend;
  logic [11:0]      win_pval;

  function automatic logic [3:0] adv(input logic [3:0] p);
    return (p == SYM_MAX) ? 4'd0 : p + 4'd1;
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] i);
    return ({1'b0, i} >= 5'(NUM_SYMBOLS)) ? SYM_MAX : i;
  endfunction

  assign thr      = {THR3, THR2, THR1};
  assign step     = (state == SPIN) && (tick == TICK_MAX);
  assign steps_n  = (&steps) ? steps : steps + 16'd1;
  assign all_stop = &(stopped | stop_now);

  // Stop decision uses the post-advance position and step count.
  always_comb begin
    stop_now = '0;
    for (int k = 0; k < 3; k++) begin
      stop_now[k] = step && !stopped[k] &&
                    (steps_n >= thr[k]) &&
                    (adv(pos[k]) == tgt[k]);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_spin) state_n = SPIN;
      SPIN:    if (all_stop) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos        <= '0;
      tgt        <= '0;
      stopped    <= '0;
      tick       <= '0;
      steps      <= '0;
      win_pend   <= 1'b0;
      win_pval   <= '0;
      win_disp   <= '0;
      win_show   <= 1'b0;
      total_disp <= '0;
    end else begin
      if (is_total) total_disp <= total_credits;
      unique case (state)
        IDLE: begin
          if (start_spin) begin
            tgt      <= {clamp(reel3_idx), clamp(reel2_idx),
                         clamp(reel1_idx)};
            tick     <= '0;
            steps    <= '0;
            stopped  <= '0;
            win_show <= 1'b0;
            win_pend <= is_win;
            if (is_win) win_pval <= win_credits;
          end else if (is_win) begin
            win_disp <= win_credits;
            win_show <= 1'b1;
          end
        end
        SPIN: begin
          if (is_win) begin
            win_pend <= 1'b1;
            win_pval <= win_credits;
          end
          tick <= step ? '0 : tick + 1'b1;
          if (step) begin
            steps <= steps_n;
            for (int k = 0; k < 3; k++) begin
              if (!stopped[k]) pos[k] <= adv(pos[k]);
              if (stop_now[k]) stopped[k] <= 1'b1;
            end
          end
        end
        DONE: begin
          // A win arriving in this very cycle is newer than the pending one.
          if (is_win) begin
            win_disp <= win_credits;
            win_show <= 1'b1;
          end else if (win_pend) begin
            win_disp <= win_pval;
            win_show <= 1'b1;
          end
          win_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign reel1_pos = pos[0];
  assign reel2_pos = pos[1];
  assign reel3_pos = pos[2];
  assign spinning  = (state == SPIN);
  assign spin_done = (state == DONE);

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Bench for reel_spin_ctrl: scoreboarded spins checked cycle by cycle
// against a positional model, plus credit latching and reset cases.
module tb_reel_spin_ctrl;

  localparam int N  = 10;
  localparam int SD = 2;
  localparam int MS = 20;
  localparam int ST = 10;

  logic        clk;
  logic        reset_n;
  logic        start_spin;
  logic [3:0]  reel1_idx, reel2_idx, reel3_idx;
  logic        is_win;
  logic [11:0] win_credits;
  logic        is_total;
  logic [11:0] total_credits;
  logic [3:0]  reel1_pos, reel2_pos, reel3_pos;
  logic        spinning, spin_done, win_show;
  logic [11:0] win_disp, total_disp;

  reel_spin_ctrl #(
    .NUM_SYMBOLS(N), .STEP_DIV(SD),
    .MIN_STEPS(MS), .STAGGER_STEPS(ST)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .start_spin(start_spin),
    .reel1_idx(reel1_idx), .reel2_idx(reel2_idx),
    .reel3_idx(reel3_idx),
    .is_win(is_win), .win_credits(win_credits),
    .is_total(is_total), .total_credits(total_credits),
    .reel1_pos(reel1_pos), .reel2_pos(reel2_pos),
    .reel3_pos(reel3_pos),
    .spinning(spinning), .spin_done(spin_done),
    .win_disp(win_disp), .win_show(win_show),
    .total_disp(total_disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][3:0]  p;
    logic [2:0][15:0] n;
    logic [15:0]      last;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [3:0]  mp[3];
  logic [11:0] exp_wd, exp_td, pend_v;
  logic        exp_ws, pend;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cur_pos(input int r);
    return (r == 0) ? reel1_pos : (r == 1) ? reel2_pos : reel3_pos;
  endfunction

  task automatic chk_outs(input string tag);
    for (int r = 0; r < 3; r++)
      chk($sformatf("%s_pos%0d", tag, r + 1),
          16'(cur_pos(r)), 16'(mp[r]));
    chk({tag, "_spinning"}, 16'(spinning), 16'(0));
    chk({tag, "_done"}, 16'(spin_done), 16'(0));
    chk({tag, "_win_disp"}, 16'(win_disp), 16'(exp_wd));
    chk({tag, "_win_show"}, 16'(win_show), 16'(exp_ws));
    chk({tag, "_total"}, 16'(total_disp), 16'(exp_td));
  endtask

  task automatic start(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic w,
                       input logic [11:0] wv);
    exp_t e;
    logic [3:0] t[3];
    int thr, base, nn;
    @(negedge clk);
    start_spin = 1'b1;
    reel1_idx = a; reel2_idx = b; reel3_idx = c;
    is_win = w; win_credits = wv;
    t[0] = a; t[1] = b; t[2] = c;
    e.last = '0;
    for (int r = 0; r < 3; r++) begin
      if (int'(t[r]) >= N) t[r] = 4'(N - 1);
      thr  = MS + r * ST;
      base = (int'(mp[r]) + thr) % N;
      nn   = thr + ((int'(t[r]) - base + N) % N);
      e.p[r] = mp[r];
      e.n[r] = 16'(nn);
      if (16'(nn) > e.last) e.last = 16'(nn);
      mp[r] = t[r];
    end
    sb.push_back(e);
    exp_ws = 1'b0;
    pend = w;
    if (w) pend_v = wv;
    @(posedge clk);
    #1;
    start_spin = 1'b0;
    is_win = 1'b0;
  endtask

  task automatic run(input int inj_k, input int win_k,
                     input logic [11:0] wv, input int tot_k,
                     input logic [11:0] tv, input int abort_k);
    exp_t e;
    int dk, s, m;
    e = sb.pop_front();
    dk = int'(e.last) * SD;
    for (int k = 0; k <= dk; k++) begin
      @(negedge clk);
      start_spin = 1'b0; is_win = 1'b0; is_total = 1'b0;
      if (k == tot_k + 1) exp_td = tv;
      if (k == abort_k) begin
        reset_n = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) mp[r] = '0;
        exp_wd = '0; exp_ws = 1'b0; exp_td = '0; pend = 1'b0;
        chk_outs("abort_now");
        repeat (3) begin
          @(negedge clk);
          chk_outs("abort_hold");
        end
        reset_n = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk_outs("abort_after");
        end
        return;
      end
      s = k / SD;
      for (int r = 0; r < 3; r++) begin
        m = (s < int'(e.n[r])) ? s : int'(e.n[r]);
        chk($sformatf("pos%0d_k%0d", r + 1, k),
            16'(cur_pos(r)), 16'((int'(e.p[r]) + m) % N));
      end
      chk($sformatf("spinning_k%0d", k), 16'(spinning),
          16'(k < dk));
      chk($sformatf("done_k%0d", k), 16'(spin_done), 16'(k == dk));
      chk($sformatf("win_show_k%0d", k), 16'(win_show), 16'(exp_ws));
      chk($sformatf("win_disp_k%0d", k), 16'(win_disp), 16'(exp_wd));
      chk($sformatf("total_k%0d", k), 16'(total_disp), 16'(exp_td));
      if (k == inj_k) begin
        start_spin = 1'b1;
        reel1_idx = 4'd1; reel2_idx = 4'd1; reel3_idx = 4'd1;
      end
      if (k == win_k) begin
        is_win = 1'b1; win_credits = wv;
        pend = 1'b1; pend_v = wv;
      end
      if (k == tot_k) begin
        is_total = 1'b1; total_credits = tv;
      end
    end
    @(negedge clk);
    start_spin = 1'b0; is_win = 1'b0; is_total = 1'b0;
    if (dk == tot_k) exp_td = tv;
    if (pend) begin
      exp_wd = pend_v; exp_ws = 1'b1; pend = 1'b0;
    end
    chk_outs("post_done");
    repeat (6) begin
      @(negedge clk);
      chk_outs("idle_after");
    end
  endtask

  initial begin
    reset_n = 1'b0; start_spin = 1'b0; is_win = 1'b0; is_total = 1'b0;
    reel1_idx = '0; reel2_idx = '0; reel3_idx = '0;
    win_credits = '0; total_credits = '0;
    for (int r = 0; r < 3; r++) mp[r] = '0;
    exp_wd = '0; exp_ws = 1'b0; exp_td = '0; pend = 1'b0; pend_v = '0;
    repeat (2) @(negedge clk);
    chk_outs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_outs("reset_rel");

    is_total = 1'b1; total_credits = 12'h3E8;
    @(negedge clk);
    is_total = 1'b0;
    exp_td = 12'h3E8;
    chk_outs("idle_total");

    is_win = 1'b1; win_credits = 12'h055;
    @(negedge clk);
    is_win = 1'b0;
    exp_wd = 12'h055; exp_ws = 1'b1;
    chk_outs("idle_win");

    start(4'd3, 4'd7, 4'd0, 1'b0, 12'h000);
    run(-10, -10, 12'h000, -10, 12'h000, -10);

    start(4'd3, 4'd7, 4'd0, 1'b0, 12'h000);
    run(10, 20, 12'h064, 30, 12'h02A, -10);

    start(4'd15, 4'd2, 4'd5, 1'b1, 12'h0AB);
    run(-10, -10, 12'h000, 5, 12'h3E8, -10);

    start(4'd4, 4'd4, 4'd4, 1'b0, 12'h000);
    run(-10, 12, 12'h077, -10, 12'h000, 15 * SD);

    start(4'd3, 4'd7, 4'd0, 1'b0, 12'h000);
    run(-10, -10, 12'h000, -10, 12'h000, -10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
